serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial two's-complement adder/subtractor. It sits directly around a single one-bit full adder cell (A, B, CIN in; SUM, COUT out). It feeds that cell one operand bit pair per clock, LSB first, with the registered carry. It captures SUM into a result shift register and COUT into the carry register. Used where area matters more than latency, such as the multi-cycle ALU path: one adder cell replaces a WIDTH-bit ripple chain.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)
CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only in IDLE
sub  input  1  1 = a - b, 0 = a + b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  sum/difference; held until next accepted start
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow
zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low: rst_n sampled low at a rising edge -> state IDLE, and busy, done, result, cout, ovf, zero, the operand shift registers, the carry register and the counter all go to 0.
- Reset mid-operation: this applies in any state, including RUN and DONE. The operation is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> load opa=a, opb=(sub ? ~b : b), carry=sub, cnt=0, result=0, flags cleared; go to RUN.
  - start=0 -> stay in IDLE; outputs hold their values.
- RUN: at each edge:
  - s = opa[0]^opb[0]^carry.
  - carry <= majority(opa[0], opb[0], carry).
  - result <= {s, result[WIDTH-1:1]}; opa and opb shift right by 1.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, also latch cin_msb = the carry-in used for that bit, then go to DONE.
- DONE, for exactly one cycle:
  - done=1, cout=carry, ovf=cin_msb^carry, zero=(result==0).
  - Next edge -> IDLE, done=0.
  - cout, ovf and zero keep their values in IDLE until the next accepted start.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH. That is WIDTH+1 cycles, 33 for the default.
- start while busy (RUN or DONE) is ignored, not queued; changes to a, b and sub during RUN have no effect.
- A back-to-back start, asserted in the IDLE cycle right after DONE, is accepted.
- Arithmetic: result is modulo 2**WIDTH. Subtraction is a + ~b + 1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: sub behaves as above.
- Undefined: the sub port remains but is ignored. The block always adds, with opb=b and carry=0 at load, and the inversion logic is not built.

Test Plan:
1. Reset, then start with a=0x00000005, b=0x00000003, sub=0 -> exactly 33 cycles later done=1 for one cycle, result=0x00000008, cout=0, ovf=0, zero=0.
2. a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, cout=1, zero=1, ovf=0.
3. a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, ovf=1, cout=0.
4. a=5, b=7, sub=1:
   - With SERIAL_ADDER_SUB_EN: result=0xFFFFFFFE, cout=0, ovf=0.
   - Without it: result=0x0000000C.
5. Start with a=1, b=1. Pulse start with a=9, b=9 at cycle 10 of RUN -> ignored; result=2 at done. Then start again in the cycle after done -> accepted, result=18 after 33 cycles.
6. Drive rst_n=0 for one edge at cycle 15 of RUN -> IDLE, all outputs 0, no done pulse. Then a=2, b=3 -> result=5.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder/subtractor around one full-adder cell.
// The SERIAL_ADDER_SUB_EN macro builds the subtract path; without it, sub is ignored and the block always adds.
module serial_adder #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] opa, opb, opb_ld;
   logic [CNT_W-1:0] cnt;
   logic carry, cin_ld, s, c_nx, last;
`ifdef SERIAL_ADDER_SUB_EN
   assign opb_ld = sub ? ~b : b;
   assign cin_ld = sub;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign opb_ld = b;
   assign cin_ld = 1'b0;
`endif
   assign s = opa[0] ^ opb[0] ^ carry;
   assign c_nx = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
   assign last = cnt == CNT_W'(WIDTH - 1);
   assign busy = state != IDLE;
   assign done = state == DONE;
   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // next-state: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE lasts one cycle
   always_comb begin
      state_nx = state;
      if (state == IDLE) state_nx = start ? RUN : IDLE;
      else if (state == RUN) state_nx = last ? DONE : RUN;
      else state_nx = IDLE;
   end
   // datapath: load on accepted start, one bit per clock in RUN, flags latched with the MSB
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opa <= '0;
         opb <= '0;
         carry <= 1'b0;
         cnt <= '0;
         result <= '0;
         cout <= 1'b0;
         ovf <= 1'b0;
         zero <= 1'b0;
      end else if (state == IDLE && start) begin
         opa <= a;
         opb <= opb_ld;
         carry <= cin_ld;
         cnt <= '0;
         result <= '0;
         cout <= 1'b0;
         ovf <= 1'b0;
         zero <= 1'b0;
      end else if (state == RUN) begin
         opa <= opa >> 1;
         opb <= opb >> 1;
         carry <= c_nx;
         cnt <= cnt + 1'b1;
         result <= {s, result[WIDTH-1:1]};
         if (last) begin
            cout <= c_nx;
            ovf <= carry ^ c_nx;
            zero <= {s, result[WIDTH-1:1]} == '0;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
   localparam int W = 32;
   logic clk = 0, rst_n = 0, start = 0, sub = 0;
   logic [W-1:0] a = '0, b = '0, result;
   logic busy, done, cout, ovf, zero;
   int cyc = 0, n_cmp = 0, n_bad = 0, acc;
   typedef struct {logic [W-1:0] r; logic c, o, z; int due;} exp_t;
   exp_t q[$];
   exp_t last_e;
   logic prev_done = 0;

   serial_adder #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
      exp_t e;
      logic ef;
      logic [W:0] u;
      logic signed [W:0] sx;
`ifdef SERIAL_ADDER_SUB_EN
      ef = sb;
`else
      ef = 1'b0;
`endif
      u = {1'b0, x} + {1'b0, y};
      sx = ef ? $signed({x[W-1], x}) - $signed({y[W-1], y}) : $signed({x[W-1], x}) + $signed({y[W-1], y});
      e.r = ef ? x - y : x + y;
      e.c = ef ? (x >= y) : u[W];
      e.o = sx[W] != sx[W-1];
      e.z = e.r == '0;
      e.due = 0;
      return e;
   endfunction

   // monitor: pop the expected response whenever done is presented
   always @(negedge clk) begin
      if (prev_done) chk("done_pulse", {63'd0, done}, 64'd0);
      prev_done <= done;
      if (rst_n && done) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 want no pending op");
         end else begin
            last_e = q.pop_front();
            chk("result", {32'd0, result}, {32'd0, last_e.r});
            chk("cout", {63'd0, cout}, {63'd0, last_e.c});
            chk("ovf", {63'd0, ovf}, {63'd0, last_e.o});
            chk("zero", {63'd0, zero}, {63'd0, last_e.z});
            chk("latency", 64'(cyc), 64'(last_e.due));
         end
      end
   end

   task automatic go(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
      exp_t e;
      @(negedge clk);
      a = x;
      b = y;
      sub = sb;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      acc = cyc;
      chk("busy_run", {63'd0, busy}, 64'd1);
      e = model(x, y, sb);
      e.due = acc + W;
      q.push_back(e);
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done want done within 100 cycles");
      end
   endtask

   task automatic hold_check(input int k);
      repeat (k) @(negedge clk);
      chk("hold_result", {32'd0, result}, {32'd0, last_e.r});
      chk("hold_flags", {61'd0, cout, ovf, zero}, {61'd0, last_e.c, last_e.o, last_e.z});
      chk("idle_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {30'd0, busy, done, result}, 64'd0);
      chk("reset_flags", {61'd0, cout, ovf, zero}, 64'd0);
      rst_n = 1;
      go(32'h5, 32'h3, 0); wait_done(); hold_check(2);
      go(32'hFFFFFFFF, 32'h1, 0); wait_done(); hold_check(1);
      go(32'h7FFFFFFF, 32'h1, 0); wait_done(); hold_check(1);
      go(32'd5, 32'd7, 1); wait_done(); hold_check(1);
      go(32'd1, 32'd1, 0);
      repeat (10) @(negedge clk);
      a = 32'd9;
      b = 32'd9;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      wait_done();
      go(32'd9, 32'd9, 0); wait_done(); hold_check(1);
      go(32'h12345678, 32'h11111111, 0);
      repeat (15) @(negedge clk);
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      q.delete();
      @(negedge clk);
      chk("midrst_outs", {30'd0, busy, done, result}, 64'd0);
      chk("midrst_flags", {61'd0, cout, ovf, zero}, 64'd0);
      repeat (40) @(negedge clk);
      go(32'd2, 32'd3, 0); wait_done(); hold_check(1);
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] x, y;
         x = (i % 5 == 0) ? 32'h80000000 : $urandom;
         y = (i % 7 == 0) ? x : $urandom;
         go(x, y, 1'($urandom_range(0, 1)));
         wait_done();
         if ($urandom_range(0, 1)) hold_check($urandom_range(1, 3));
      end
      repeat (5) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
